// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - glyph constants and width helper shared by the segment scanner
package seg_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-low segments, bit order {dp,g,f,e,d,c,b,a}; dp always off here.
    localparam logic [7:0] GLYPH_0 = 8'hC0;
    localparam logic [7:0] GLYPH_1 = 8'hF9;
    localparam logic [7:0] GLYPH_2 = 8'hA4;
    localparam logic [7:0] GLYPH_3 = 8'hB0;
    localparam logic [7:0] GLYPH_4 = 8'h99;
    localparam logic [7:0] GLYPH_5 = 8'h92;
    localparam logic [7:0] GLYPH_6 = 8'h82;
    localparam logic [7:0] GLYPH_7 = 8'hF8;
    localparam logic [7:0] GLYPH_8 = 8'h80;
    localparam logic [7:0] GLYPH_9 = 8'h90;
    localparam logic [7:0] GLYPH_A = 8'h88;
    localparam logic [7:0] GLYPH_B = 8'h83;
    localparam logic [7:0] GLYPH_C = 8'hC6;
    localparam logic [7:0] GLYPH_D = 8'hA1;
    localparam logic [7:0] GLYPH_E = 8'h86;
    localparam logic [7:0] GLYPH_F = 8'h8E;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg_decoder.sv
// rtl/seg_decoder.sv - hex code to active-low segment pattern with dp and blanking
module seg_decoder
    import seg_pkg::*;
(
    input  logic [3:0] code,
    input  logic       dp_on,
    input  logic       dark,
    output logic [7:0] seg
);

    logic [7:0] glyph;

    always_comb begin
        glyph = SEG_OFF;
        case (code)
            4'h0: glyph = GLYPH_0;
            4'h1: glyph = GLYPH_1;
            4'h2: glyph = GLYPH_2;
            4'h3: glyph = GLYPH_3;
            4'h4: glyph = GLYPH_4;
            4'h5: glyph = GLYPH_5;
            4'h6: glyph = GLYPH_6;
            4'h7: glyph = GLYPH_7;
            4'h8: glyph = GLYPH_8;
            4'h9: glyph = GLYPH_9;
            4'hA: glyph = GLYPH_A;
            4'hB: glyph = GLYPH_B;
            4'hC: glyph = GLYPH_C;
            4'hD: glyph = GLYPH_D;
            4'hE: glyph = GLYPH_E;
            4'hF: glyph = GLYPH_F;
        endcase
    end

    always_comb begin
        seg = {glyph[7] & ~dp_on, glyph[6:0]};
        if (dark) begin
            seg = SEG_OFF;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed 7-segment scanner with double-buffered image and blink
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int DIV_COUNT    = 10000,
    parameter int GHOST_CYCLES = 4,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clock,
    input  logic                    sys_rst_n,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [4*NUM_DIGITS-1:0] wr_code,
    input  logic [NUM_DIGITS-1:0]   wr_blank,
    input  logic [NUM_DIGITS-1:0]   wr_dp,
    input  logic [NUM_DIGITS-1:0]   wr_blink,
    output logic [NUM_DIGITS-1:0]   control,
    output logic [7:0]              cube_data,
    output logic                    frame_tick
);

    localparam int IW = idx_width(NUM_DIGITS);
    localparam int DW = idx_width(DIV_COUNT);
    localparam int BW = idx_width(BLINK_FRAMES);

    logic [DW-1:0]           div_q, div_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [BW-1:0]           blink_cnt_q, blink_cnt_d;
    logic                    phase_q, phase_d;
    logic                    pending_q, pending_d;
    logic [4*NUM_DIGITS-1:0] act_code_q, act_code_d, shd_code_q, shd_code_d;
    logic [NUM_DIGITS-1:0]   act_blank_q, act_blank_d, shd_blank_q, shd_blank_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d, shd_dp_q, shd_dp_d;
    logic [NUM_DIGITS-1:0]   act_blink_q, act_blink_d, shd_blink_q, shd_blink_d;
    logic [NUM_DIGITS-1:0]   control_q, control_d;
    logic [7:0]              cube_q, cube_d;

    logic                    slot_end, last_digit, wrap, in_ghost;
    logic [3:0]              cur_code;
    logic                    cur_dp, cur_dark;
    logic [NUM_DIGITS-1:0]   digit_sel_n;
    logic [7:0]              dec_seg;

    // Select the current digit's fields from the active buffer only.
    always_comb begin
        cur_code    = 4'h0;
        cur_dp      = 1'b0;
        cur_dark    = 1'b1;
        digit_sel_n = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_code       = act_code_q[4*i +: 4];
                cur_dp         = act_dp_q[i];
                cur_dark       = act_blank_q[i] | (act_blink_q[i] & phase_q);
                digit_sel_n[i] = 1'b0;
            end
        end
    end

    seg_decoder u_seg_decoder (
        .code  (cur_code),
        .dp_on (cur_dp),
        .dark  (cur_dark),
        .seg   (dec_seg)
    );

    always_comb begin
        slot_end   = (div_q == DW'(DIV_COUNT - 1));
        last_digit = (idx_q == IW'(NUM_DIGITS - 1));
        wrap       = slot_end && last_digit;
        in_ghost   = (div_q < DW'(GHOST_CYCLES));

        div_d       = slot_end ? '0 : div_q + 1'b1;
        idx_d       = idx_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        pending_d   = pending_q;
        act_code_d  = act_code_q;
        act_blank_d = act_blank_q;
        act_dp_d    = act_dp_q;
        act_blink_d = act_blink_q;
        shd_code_d  = shd_code_q;
        shd_blank_d = shd_blank_q;
        shd_dp_d    = shd_dp_q;
        shd_blink_d = shd_blink_q;

        if (slot_end) begin
            idx_d = last_digit ? '0 : idx_q + 1'b1;
        end

        if (wrap) begin
            if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end

        // Commit only at a frame boundary so one frame never mixes images;
        // while pending, wr_ready is low so a capture cannot collide here.
        if (wrap && pending_q) begin
            act_code_d  = shd_code_q;
            act_blank_d = shd_blank_q;
            act_dp_d    = shd_dp_q;
            act_blink_d = shd_blink_q;
            pending_d   = 1'b0;
        end else if (wr_valid && !pending_q) begin
            shd_code_d  = wr_code;
            shd_blank_d = wr_blank;
            shd_dp_d    = wr_dp;
            shd_blink_d = wr_blink;
            pending_d   = 1'b1;
        end

        control_d = in_ghost ? '1 : digit_sel_n;
        cube_d    = in_ghost ? SEG_OFF : dec_seg;
    end

    always_ff @(posedge clock) begin
        if (sys_rst_n) begin
            div_q       <= '0;
            idx_q       <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            pending_q   <= 1'b0;
            act_code_q  <= '0;
            act_blank_q <= '1;
            act_dp_q    <= '0;
            act_blink_q <= '0;
            shd_code_q  <= '0;
            shd_blank_q <= '1;
            shd_dp_q    <= '0;
            shd_blink_q <= '0;
            control_q   <= '1;
            cube_q      <= SEG_OFF;
        end else begin
            div_q       <= div_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            pending_q   <= pending_d;
            act_code_q  <= act_code_d;
            act_blank_q <= act_blank_d;
            act_dp_q    <= act_dp_d;
            act_blink_q <= act_blink_d;
            shd_code_q  <= shd_code_d;
            shd_blank_q <= shd_blank_d;
            shd_dp_q    <= shd_dp_d;
            shd_blink_q <= shd_blink_d;
            control_q   <= control_d;
            cube_q      <= cube_d;
        end
    end

    assign control    = control_q;
    assign cube_data  = cube_q;
    assign wr_ready   = ~pending_q;
    assign frame_tick = wrap & ~sys_rst_n;

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 8: number of multiplexed digits; legal range 1..16.
REQ-002 Parameter DIV_COUNT, default 10000: clock cycles per digit slot; SHALL be >= GHOST_CYCLES+2.
REQ-003 Parameter GHOST_CYCLES, default 4: all-off cycles at the start of each slot.
REQ-004 Parameter BLINK_FRAMES, default 64: frames per blink half-period.
REQ-005 clock  in  1: the single clock; all logic SHALL be clocked on its rising edge.
REQ-006 sys_rst_n  in  1: reset, synchronous and active-high despite the name.
REQ-007 wr_valid  in  1: new display image offered.
REQ-008 wr_ready  out  1: image can be accepted.
REQ-009 wr_code  in  4*NUM_DIGITS: hex code per digit; digit i uses bits [4i+3:4i].
REQ-010 wr_blank  in  NUM_DIGITS: per-digit blank mask; 1 = off.
REQ-011 wr_dp  in  NUM_DIGITS: per-digit decimal point; 1 = lit.
REQ-012 wr_blink  in  NUM_DIGITS: per-digit blink enable.
REQ-013 control  out  NUM_DIGITS: digit select, active-low; digit i drives bit i; digit NUM_DIGITS-1 is leftmost.
REQ-014 cube_data  out  8: segments, active-low, order {dp,g,f,e,d,c,b,a}.
REQ-015 frame_tick  out  1: one-cycle pulse at each frame wrap.

Function
REQ-016 The divider SHALL count 0..DIV_COUNT-1 and wrap; the wrap cycle SHALL end the current slot.
REQ-017 The digit index SHALL advance 0,1,..,NUM_DIGITS-1,0 at each slot end; scan order SHALL be index ascending.
REQ-018 For divider values 0..GHOST_CYCLES-1, control and cube_data SHALL be all ones (ghost gap).
REQ-019 For the remaining slot cycles, exactly one control bit (the current index) SHALL be 0.
REQ-020 control and cube_data SHALL be registered, lagging divider/index state by exactly 1 cycle.
REQ-021 Decode: codes 0-F SHALL map to standard hex glyphs; 0 = 8'b11000000, 8 = 8'b10000000.
REQ-022 The dp bit SHALL be 0 when wr_dp is set for the digit, independent of the code.
REQ-023 A digit SHALL show 8'b11111111 when blanked, or when blink-enabled and the blink phase is 1.
REQ-024 Frame wrap: the cycle the index goes NUM_DIGITS-1 -> 0; frame_tick SHALL pulse high on that cycle only.
REQ-025 The blink counter SHALL count frames; the phase SHALL toggle after every BLINK_FRAMES frames.
REQ-026 Handshake: transfer occurs when wr_valid && wr_ready; the data SHALL be captured into the shadow buffer and pending set.
REQ-027 wr_ready SHALL equal !pending; wr_valid SHALL NOT be required to stay high.
REQ-028 At a frame wrap with pending=1 at the start of that cycle, the shadow SHALL copy to the active buffer and pending SHALL clear.
REQ-029 A transfer on a wrap cycle SHALL commit at the following wrap, never mid-frame.
REQ-030 The displayed image SHALL never mix two buffers within one frame.

Reset
REQ-031 While sys_rst_n=1 at a clock edge, the block SHALL reset: divider=0, index=0, pending=0, blink counter and phase=0.
REQ-032 Reset values: active and shadow buffers all-blank, control all ones, cube_data all ones, frame_tick=0, wr_ready=1.
REQ-033 Reset mid-slot or mid-handshake SHALL discard pending data; scanning SHALL restart at index 0 with the ghost gap.

Structure
REQ-034 The shared package seg_pkg SHALL hold the 16 glyph constants, the SEG_OFF constant (8'hFF), and the digit-index width function.
REQ-035 Code-to-segment decode SHALL live in one combinational sub-module, seg_decoder.
REQ-036 The index width SHALL be $clog2(NUM_DIGITS), minimum 1.

Verification (NUM_DIGITS=4, DIV_COUNT=8, GHOST_CYCLES=2, BLINK_FRAMES=2)
REQ-037 Reset -> control=4'b1111, cube_data=8'hFF, wr_ready=1; after the first frame, all digits stay dark.
REQ-038 Write codes {3,2,1,0}, blank=0, dp=0 -> next frame per slot: 2 cycles 4'b1111, then 6 cycles control=4'b1110 with cube_data=8'hC0 (digit 0, code 0), then 4'b1101 with 8'hF9, and so on.
REQ-039 Write on a non-wrap cycle -> wr_ready=0 until the wrap, rises the cycle after; a second write while not ready is ignored.
REQ-040 Write asserted exactly on a wrap cycle -> old image for one more full frame; new image the frame after.
REQ-041 wr_blink=4'b0001, wr_dp=4'b0010 -> digit 0 dark for frames 2-3 and lit for frames 0-1 and 4-5; digit 1 shows the dp bit low.
REQ-042 sys_rst_n pulsed mid-slot with a write pending -> outputs all ones the next cycle, pending lost, scan restarts at index 0.
